// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator.
//   state_e     : run-control states of the raster sequencer
//   DEF_*       : 640x480@60 default line/frame geometry
//   win_t       : half-open [first, last) column/line window
//   syncWindow  : computes the sync window from active, porch and width
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [31:0] first;  // first position inside the window
    logic [31:0] last;   // first position after the window
  } win_t;

  // Sync sits directly after active + front porch.
  function automatic win_t syncWindow(input int actLen, input int porchLen, input int syncLen);
    win_t w;
    w.first = 32'(actLen + porchLen);
    w.last  = 32'(actLen + porchLen + syncLen);
    return w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// Parametrised register chain used to align strobes with pixel-pipeline latency.
//   vgaClk : clock
//   nrst   : asynchronous active-low reset, loads RST_VAL into every stage
//   din    : WIDTH-bit input
//   dout   : din delayed by DEPTH cycles (DEPTH = 0 is a plain wire)
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vgaClk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : gWire
    // Clock and reset have no load in the zero-depth case.
    logic unusedClkRst;
    assign unusedClkRst = vgaClk ^ nrst;
    assign dout = din;
  end else begin : gShift
    logic [WIDTH-1:0] stages [DEPTH];

    // Shift chain; stage 0 captures din, last stage drives dout.
    always_ff @(posedge vgaClk or negedge nrst) begin
      if (!nrst) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
//   vgaClk, nrst        : pixel clock, asynchronous active-low reset
//   en                  : level-sensitive run request; stopping waits for frame end
//   hSync, vSync        : sync strobes (polarity HS_POL/VS_POL), delayed by PIPE
//   blankB, active      : visible-pixel strobe, delayed by PIPE
//   syncB               : tied low
//   hCount, vCount      : raw raster position, undelayed
//   lineStart/frameStart: pulses at column 0 / position (0,0) while running
//   frameCount          : frames started, wraps
//   running             : sequencer not idle
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = 11,
  parameter int FCW      = 8,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2
) (
  input  logic           vgaClk,
  input  logic           nrst,
  input  logic           en,
  output logic           hSync,
  output logic           vSync,
  output logic           blankB,
  output logic           syncB,
  output logic           active,
  output logic [CW-1:0]  hCount,
  output logic [CW-1:0]  vCount,
  output logic           lineStart,
  output logic           frameStart,
  output logic [FCW-1:0] frameCount,
  output logic           running
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam win_t H_WIN = syncWindow(H_ACTIVE, H_FP, H_SYNC);
  localparam win_t V_WIN = syncWindow(V_ACTIVE, V_FP, V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
  localparam logic [31:0] H_ACT_U = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_U = 32'(V_ACTIVE);

  if (H_TOT > (2 ** CW)) begin : gHTotCheck
    $error("vga_timing_gen: H_TOT does not fit in CW bits");
  end
  if (V_TOT > (2 ** CW)) begin : gVTotCheck
    $error("vga_timing_gen: V_TOT does not fit in CW bits");
  end

  state_e        state, stateNext;
  logic [CW-1:0] hNext, vNext, hStep, vStep;
  logic          hEnd, frameEnd;
  logic          hsRaw, vsRaw, actRaw;
  logic [2:0]    dlyOut;

  // Next-state and next-position decode for the raster sequencer.
  always_comb begin
    hEnd      = (hCount == H_LAST);
    frameEnd  = hEnd && (vCount == V_LAST);
    hStep     = hEnd ? {CW{1'b0}} : hCount + CW'(1);
    vStep     = hEnd ? (frameEnd ? {CW{1'b0}} : vCount + CW'(1)) : vCount;
    stateNext = state;
    hNext     = hCount;
    vNext     = vCount;
    case (state)
      IDLE: begin
        hNext = {CW{1'b0}};
        vNext = {CW{1'b0}};
        if (en) stateNext = RUN;
        else    stateNext = IDLE;
      end
      RUN: begin
        hNext = hStep;
        vNext = vStep;
        if (!en) stateNext = STOPPING;
        else     stateNext = RUN;
      end
      STOPPING: begin
        // The frame-end wrap already yields (0,0), which is IDLE's hold value.
        hNext = hStep;
        vNext = vStep;
        if (frameEnd) stateNext = IDLE;
        else if (en)  stateNext = RUN;
        else          stateNext = STOPPING;
      end
      default: begin
        stateNext = IDLE;
        hNext     = {CW{1'b0}};
        vNext     = {CW{1'b0}};
      end
    endcase
  end

  // Sequencer state, counters and undelayed strobes; strobes are decoded
  // from the next values so they line up with the registered counters.
  always_ff @(posedge vgaClk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      hCount     <= {CW{1'b0}};
      vCount     <= {CW{1'b0}};
      running    <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      frameCount <= {FCW{1'b0}};
    end else begin
      state      <= stateNext;
      hCount     <= hNext;
      vCount     <= vNext;
      running    <= (stateNext != IDLE);
      lineStart  <= (stateNext != IDLE) && (hNext == {CW{1'b0}});
      frameStart <= (stateNext != IDLE) && (hNext == {CW{1'b0}}) && (vNext == {CW{1'b0}});
      if (frameStart) frameCount <= frameCount + FCW'(1);
      else            frameCount <= frameCount;
    end
  end

  // Raw sync/visible decode from the current raster position.
  always_comb begin
    hsRaw  = ~HS_POL;
    vsRaw  = ~VS_POL;
    actRaw = 1'b0;
    if (state != IDLE) begin
      if ((32'(hCount) >= H_WIN.first) && (32'(hCount) < H_WIN.last)) hsRaw = HS_POL;
      else                                                             hsRaw = ~HS_POL;
      if ((32'(vCount) >= V_WIN.first) && (32'(vCount) < V_WIN.last)) vsRaw = VS_POL;
      else                                                             vsRaw = ~VS_POL;
      actRaw = (32'(hCount) < H_ACT_U) && (32'(vCount) < V_ACT_U);
    end else begin
      hsRaw  = ~HS_POL;
      vsRaw  = ~VS_POL;
      actRaw = 1'b0;
    end
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) uDelay (
    .vgaClk (vgaClk),
    .nrst   (nrst),
    .din    ({hsRaw, vsRaw, actRaw}),
    .dout   (dlyOut)
  );

  assign hSync  = dlyOut[2];
  assign vSync  = dlyOut[1];
  assign blankB = dlyOut[0];
  assign active = dlyOut[0];
  assign syncB  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two instances: A = scaled geometry with PIPE=2 and active-low syncs,
// B = tiny geometry (14x7) with PIPE=0 and active-high hSync.
module tb_vga_timing_gen;

  localparam int AHA = 40, AHF = 4, AHS = 8, AHB = 4;
  localparam int AVA = 12, AVF = 2, AVS = 2, AVB = 3;
  localparam int AHT = AHA + AHF + AHS + AHB;  // 56
  localparam int AVT = AVA + AVF + AVS + AVB;  // 19
  localparam int APIPE = 2;
  localparam int BHA = 8, BHF = 2, BHS = 2, BHB = 2;
  localparam int BVA = 4, BVF = 1, BVS = 1, BVB = 1;
  localparam int BHT = BHA + BHF + BHS + BHB;  // 14
  localparam int BVT = BVA + BVF + BVS + BVB;  // 7

  logic vgaClk = 1'b0;
  logic nrst   = 1'b0;
  logic enA    = 1'b0;
  logic enB    = 1'b0;

  logic        hSyncA, vSyncA, blankBA, syncBA, activeA, lineStartA, frameStartA, runningA;
  logic [10:0] hCountA, vCountA;
  logic [7:0]  frameCountA;
  logic        hSyncB, vSyncB, blankBB, syncBB, activeB, lineStartB, frameStartB, runningB;
  logic [3:0]  hCountB, vCountB;
  logic [2:0]  frameCountB;

  always #5 vgaClk = ~vgaClk;

  vga_timing_gen #(
    .CW(11), .FCW(8), .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(APIPE)
  ) dutA (
    .vgaClk(vgaClk), .nrst(nrst), .en(enA), .hSync(hSyncA), .vSync(vSyncA),
    .blankB(blankBA), .syncB(syncBA), .active(activeA), .hCount(hCountA),
    .vCount(vCountA), .lineStart(lineStartA), .frameStart(frameStartA),
    .frameCount(frameCountA), .running(runningA)
  );

  vga_timing_gen #(
    .CW(4), .FCW(3), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(0)
  ) dutB (
    .vgaClk(vgaClk), .nrst(nrst), .en(enB), .hSync(hSyncB), .vSync(vSyncB),
    .blankB(blankBB), .syncB(syncBB), .active(activeB), .hCount(hCountB),
    .vCount(vCountB), .lineStart(lineStartB), .frameStart(frameStartB),
    .frameCount(frameCountB), .running(runningB)
  );

  int compCount = 0;
  int failCount = 0;

  // Reference model state per instance (0 = A, 1 = B); mst: 0 idle, 1 run, 2 stopping.
  int mh [2];
  int mv [2];
  int mst [2];
  int mfc [2];
  // Scoreboard of expected {hSync, vSync, blankB}, in the order the DUT must emit them.
  logic [2:0] qA [$];
  logic [2:0] qB [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic modelReset(input int i);
    mh[i] = 0; mv[i] = 0; mst[i] = 0; mfc[i] = 0;
    if (i == 0) begin
      qA.delete();
      for (int k = 0; k < APIPE; k++) qA.push_back(3'b110);
    end else begin
      qB.delete();
    end
  endtask

  // Advance the model by one clock edge using the input about to be sampled.
  task automatic modelStep(input int i, input logic en);
    int ht, vt, mask;
    bit atEnd;
    ht   = (i == 0) ? AHT : BHT;
    vt   = (i == 0) ? AVT : BVT;
    mask = (i == 0) ? 255 : 7;
    if (!nrst) begin
      modelReset(i);
    end else if (mst[i] == 0) begin
      if (en) mst[i] = 1;
    end else begin
      atEnd = (mh[i] == ht - 1) && (mv[i] == vt - 1);
      if (mh[i] == 0 && mv[i] == 0) mfc[i] = (mfc[i] + 1) & mask;
      if (mh[i] == ht - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
      if (mst[i] == 1) begin
        if (!en) mst[i] = 2;
      end else if (atEnd) begin
        mst[i] = 0;
      end else if (en) begin
        mst[i] = 1;
      end
    end
  endtask

  // Undelayed {hs, vs, act} implied by the model's current position.
  function automatic logic [2:0] rawExp(input int i);
    int ha, hsF, hsL, va, vsF, vsL;
    bit hp, run, inH, inV;
    ha  = (i == 0) ? AHA : BHA;
    hsF = (i == 0) ? AHA + AHF : BHA + BHF;
    hsL = (i == 0) ? AHA + AHF + AHS : BHA + BHF + BHS;
    va  = (i == 0) ? AVA : BVA;
    vsF = (i == 0) ? AVA + AVF : BVA + BVF;
    vsL = (i == 0) ? AVA + AVF + AVS : BVA + BVF + BVS;
    hp  = (i == 0) ? 1'b0 : 1'b1;
    run = (mst[i] != 0);
    inH = run && (mh[i] >= hsF) && (mh[i] < hsL);
    inV = run && (mv[i] >= vsF) && (mv[i] < vsL);
    return {inH ? hp : ~hp, inV ? 1'b0 : 1'b1, run && (mh[i] < ha) && (mv[i] < va)};
  endfunction

  task automatic checkOne(input int i, input logic [10:0] hc, input logic [10:0] vc,
                          input logic hs, input logic vs, input logic bl, input logic ac,
                          input logic ls, input logic fs, input logic rn, input logic sb,
                          input logic [7:0] fc);
    logic [2:0] e;
    string p;
    bit run;
    p   = (i == 0) ? "A" : "B";
    run = (mst[i] != 0);
    e   = rawExp(i);
    if (i == 0) begin
      qA.push_back(e);
      e = qA.pop_front();
    end else begin
      qB.push_back(e);
      e = qB.pop_front();
    end
    chk({p, ".hCount"}, 32'(hc), 32'(mh[i]));
    chk({p, ".vCount"}, 32'(vc), 32'(mv[i]));
    chk({p, ".hSync"}, 32'(hs), 32'(e[2]));
    chk({p, ".vSync"}, 32'(vs), 32'(e[1]));
    chk({p, ".blankB"}, 32'(bl), 32'(e[0]));
    chk({p, ".active"}, 32'(ac), 32'(e[0]));
    chk({p, ".running"}, 32'(rn), 32'(run));
    chk({p, ".lineStart"}, 32'(ls), 32'(run && mh[i] == 0));
    chk({p, ".frameStart"}, 32'(fs), 32'(run && mh[i] == 0 && mv[i] == 0));
    chk({p, ".frameCount"}, 32'(fc), 32'(mfc[i]));
    chk({p, ".syncB"}, 32'(sb), 32'd0);
  endtask

  task automatic checkAll();
    checkOne(0, hCountA, vCountA, hSyncA, vSyncA, blankBA, activeA, lineStartA,
             frameStartA, runningA, syncBA, frameCountA);
    checkOne(1, {7'd0, hCountB}, {7'd0, vCountB}, hSyncB, vSyncB, blankBB, activeB,
             lineStartB, frameStartB, runningB, syncBB, {5'd0, frameCountB});
  endtask

  // One clock: model takes the edge, then outputs are compared at the falling edge.
  task automatic tick();
    modelStep(0, enA);
    modelStep(1, enB);
    @(negedge vgaClk);
    checkAll();
  endtask

  function automatic logic sigv(input int sel);
    case (sel)
      0:       return frameStartA;
      1:       return lineStartA;
      2:       return ~runningA;
      3:       return ~hSyncA;
      4:       return hSyncA;
      5:       return ~runningB;
      6:       return hSyncB;
      7:       return ~hSyncB;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitSig(input int sel, input int bound, output int n);
    n = 0;
    while (!sigv(sel) && n < bound) begin
      tick();
      n++;
    end
    chk($sformatf("waitSig%0d.timeout", sel), 32'(n >= bound), 32'd0);
  endtask

  task automatic waitPos(input int i, input int h, input int v, input int bound);
    int n;
    n = 0;
    while (!(mh[i] == h && mv[i] == v) && n < bound) begin
      tick();
      n++;
    end
    chk($sformatf("waitPos%0d.timeout", i), 32'(n >= bound), 32'd0);
  endtask

  initial begin
    int n;
    modelReset(0);
    modelReset(1);

    // Reset state.
    repeat (3) tick();

    // Start both rasters; the first running cycle is (0,0) with frameStart.
    nrst = 1'b1; enA = 1'b1; enB = 1'b1;
    tick();
    chk("A.firstFrameStart", 32'(frameStartA), 32'd1);
    chk("A.firstFrameCount", 32'(frameCountA), 32'd0);

    // Frame and line periods.
    tick();
    waitSig(0, 1200, n);
    chk("A.framePeriod", 32'(n + 1), 32'(AHT * AVT));
    chk("A.secondFrameCount", 32'(frameCountA), 32'd1);
    tick();
    waitSig(1, 100, n);
    chk("A.linePeriod", 32'(n + 1), 32'(AHT));

    // Horizontal sync placement with two cycles of lag, and its width.
    waitSig(3, 100, n);
    chk("A.hSyncFallCol", 32'(hCountA), 32'(AHA + AHF + APIPE));
    waitSig(4, 100, n);
    chk("A.hSyncLowLen", 32'(n), 32'(AHS));

    // Zero-lag active-high hSync on the small configuration.
    waitSig(7, 40, n);
    waitSig(6, 40, n);
    chk("B.hSyncRiseCol", 32'(hCountB), 32'(BHA + BHF));

    // Drop en mid-frame: raster completes the frame, then idles.
    waitPos(0, 10, 5, 2200);
    enA = 1'b0;
    waitSig(2, 2200, n);
    chk("A.stopLatency", 32'(n), 32'((AHT * AVT - 1) - (5 * AHT + 10) + 1));
    chk("A.idleHCount", 32'(hCountA), 32'd0);
    repeat (150) tick();

    // Restart, drop en, re-raise before frame end: raster uninterrupted.
    enA = 1'b1;
    waitPos(0, 20, 8, 2200);
    enA = 1'b0;
    waitPos(0, 5, 10, 2200);
    enA = 1'b1;
    repeat (700) tick();
    chk("A.rerunRunning", 32'(runningA), 32'd1);

    // Stop the small raster mid-frame.
    waitPos(1, 3, 2, 200);
    enB = 1'b0;
    waitSig(5, 200, n);
    chk("B.stopLatency", 32'(n), 32'((BHT * BVT - 1) - (2 * BHT + 3) + 1));
    enB = 1'b1;
    repeat (300) tick();

    // Asynchronous reset mid-frame takes effect without a clock edge.
    nrst = 1'b0;
    #1;
    modelReset(0);
    modelReset(1);
    checkAll();
    chk("A.rstHSync", 32'(hSyncA), 32'd1);
    chk("A.rstVSync", 32'(vSyncA), 32'd1);
    chk("A.rstBlankB", 32'(blankBA), 32'd0);
    chk("A.rstRunning", 32'(runningA), 32'd0);
    chk("A.rstFrameCount", 32'(frameCountA), 32'd0);
    chk("B.rstHSync", 32'(hSyncB), 32'd0);
    repeat (2) tick();
    nrst = 1'b1;
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
